// File: rtl/gpu_cmd_sequencer.sv
// Queued command front-end for the shader array: slave-fed command FIFO, phase sequencer, pixel write-out master.
// Latency: push to FETCH in 2 cycles; WRITE_OUT issues one pixel per accepted beat. Optional GPU_PERF_COUNTERS_EN adds busy/stall counters.
// Backpressure: m1_waitrequest freezes the write-out beat; a push into a full FIFO (no same-cycle pop) is dropped and flagged.
module gpu_cmd_sequencer #(
    parameter int NUM_LANES      = 320,
    parameter int CMD_DEPTH      = 8,
    parameter int PIXEL_BITS     = 16,
    parameter int START_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int ADDR_STRIDE    = 2,
    localparam int SEL_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [7:0]            s1_address,
    input  logic                  s1_read,
    output logic [31:0]           s1_readdata,
    input  logic                  s1_write,
    input  logic [31:0]           s1_writedata,
    output logic                  s1_waitrequest,
    output logic                  irq,
    output logic [1:0]            lane_op,
    output logic [31:0]           lane_arg,
    output logic                  lane_start,
    input  logic                  lane_done,
    output logic [SEL_W-1:0]      lane_sel,
    input  logic [PIXEL_BITS-1:0] lane_pixel,
    output logic [31:0]           m1_address,
    output logic [PIXEL_BITS-1:0] m1_writedata,
    output logic                  m1_write,
    input  logic                  m1_waitrequest
);
    localparam int PTR_W = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
    localparam int LVL_W = PTR_W + 1;
    localparam int SC_W  = $clog2(START_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [1:0] OP_WRITE_OUT = 2'd2;

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_START, S_WAIT, S_WRITE, S_ERROR} state_t;
    state_t state_q, state_d;

    logic [33:0]      fifo_mem_q [CMD_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic [1:0]       op_q;
    logic [31:0]      arg_q, addr_q;
    logic [SEL_W-1:0] sel_q;
    logic [SC_W-1:0]  start_cnt_q;
    logic [TO_W-1:0]  wait_cnt_q;
    logic             ovf_q, tmo_q, err_q, drain_q;
    logic [1:0]       irq_en_q;
    logic             busy;

    logic        push_req, irq_en_wr, clr, stat_rd, fifo_empty, fifo_full;
    logic        pop, push_ok, ovf_evt, wr_accept, sel_last, start_last, wait_expired;
    logic [33:0] head;
    logic [7:0]  level8;

    assign push_req     = s1_write && (s1_address[7:2] == 6'd0);
    assign irq_en_wr    = s1_write && (s1_address == 8'h04);
    assign clr          = s1_write && (s1_address == 8'h0f) && s1_writedata[0];
    assign stat_rd      = s1_read && (s1_address == 8'h0f);
    assign fifo_empty   = (level_q == '0);
    assign fifo_full    = (level_q == LVL_W'(CMD_DEPTH));
    assign head         = fifo_mem_q[rd_ptr_q];
    assign pop          = (state_q == S_FETCH) && !fifo_empty && !clr;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push_ok      = push_req && (!fifo_full || pop);
    assign ovf_evt      = push_req && fifo_full && !pop;
    assign sel_last     = (sel_q == SEL_W'(NUM_LANES - 1));
    assign start_last   = (start_cnt_q == SC_W'(START_CYCLES - 1));
    assign wr_accept    = (state_q == S_WRITE) && !m1_waitrequest;
    assign wait_expired = (state_q == S_WAIT) && !lane_done
                          && (wait_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
    assign level8       = 8'(level_q);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (!fifo_empty) state_d = S_FETCH;
            S_FETCH: begin
                if (fifo_empty)                       state_d = S_IDLE;
                else if (head[33:32] == OP_WRITE_OUT) state_d = S_WRITE;
                else                                  state_d = S_START;
            end
            S_START: if (start_last) state_d = S_WAIT;
            S_WAIT: begin
                if (lane_done)         state_d = S_FETCH;
                else if (wait_expired) state_d = S_ERROR;
            end
            S_WRITE: if (wr_accept && sel_last) state_d = S_FETCH;
            default: state_d = state_q;
        endcase
        if (ovf_evt) state_d = S_ERROR;
        if (clr)     state_d = S_IDLE;
    end

    always_comb begin
        lane_start = 1'b0;
        m1_write   = 1'b0;
        case (state_q)
            S_START: lane_start = 1'b1;
            S_WRITE: m1_write   = 1'b1;
            default: ;
        endcase
        busy = (state_q != S_IDLE) && (state_q != S_ERROR);
    end

    always_ff @(posedge clock) begin
        if (push_ok) fifo_mem_q[wr_ptr_q] <= {s1_address[1:0], s1_writedata};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push_ok && !pop)      level_q <= level_q + 1'b1;
            else if (!push_ok && pop) level_q <= level_q - 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            op_q        <= '0;
            arg_q       <= '0;
            sel_q       <= '0;
            addr_q      <= '0;
            start_cnt_q <= '0;
            wait_cnt_q  <= '0;
        end else begin
            start_cnt_q <= (state_q == S_START) ? start_cnt_q + 1'b1 : '0;
            wait_cnt_q  <= (state_q == S_WAIT)  ? wait_cnt_q + 1'b1  : '0;
            if (pop) begin
                op_q  <= head[33:32];
                arg_q <= head[31:0];
                if (head[33:32] == OP_WRITE_OUT) begin
                    sel_q  <= '0;
                    addr_q <= head[31:0];
                end
            end
            // Address advances incrementally; the running sum wraps at 32 bits.
            if (wr_accept && !sel_last) begin
                sel_q  <= sel_q + 1'b1;
                addr_q <= addr_q + 32'(ADDR_STRIDE);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            irq_en_q <= '0;
            ovf_q    <= 1'b0;
            tmo_q    <= 1'b0;
            err_q    <= 1'b0;
            drain_q  <= 1'b0;
        end else begin
            if (irq_en_wr)              irq_en_q <= s1_writedata[1:0];
            if (ovf_evt)                ovf_q    <= 1'b1;
            if (wait_expired)           tmo_q    <= 1'b1;
            if (state_d == S_ERROR)     err_q    <= 1'b1;
            if (stat_rd)                drain_q  <= 1'b0;
            if (state_q == S_FETCH && fifo_empty) drain_q <= 1'b1;
            if (clr) begin
                ovf_q   <= 1'b0;
                tmo_q   <= 1'b0;
                err_q   <= 1'b0;
                drain_q <= 1'b0;
            end
        end
    end

`ifdef GPU_PERF_COUNTERS_EN
    logic [31:0] busy_cycles_q, stall_cycles_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy_cycles_q  <= '0;
            stall_cycles_q <= '0;
        end else if (clr) begin
            busy_cycles_q  <= '0;
            stall_cycles_q <= '0;
        end else begin
            if (busy) busy_cycles_q <= busy_cycles_q + 1'b1;
            if (state_q == S_WRITE && m1_waitrequest) stall_cycles_q <= stall_cycles_q + 1'b1;
        end
    end
`endif

    always_comb begin
        s1_readdata = '0;
        case (s1_address)
            8'h04: s1_readdata = {30'd0, irq_en_q};
            8'h0f: s1_readdata = {16'd0, level8, 4'd0, tmo_q, ovf_q, err_q, busy};
`ifdef GPU_PERF_COUNTERS_EN
            8'h08: s1_readdata = busy_cycles_q;
            8'h09: s1_readdata = stall_cycles_q;
`endif
            default: s1_readdata = '0;
        endcase
    end

    assign s1_waitrequest = 1'b0;
    assign irq            = (drain_q & irq_en_q[0]) | (err_q & irq_en_q[1]);
    assign lane_op        = op_q;
    assign lane_arg       = arg_q;
    assign lane_sel       = sel_q;
    assign m1_address     = addr_q;
    assign m1_writedata   = lane_pixel;

endmodule

// File: tb/tb_gpu_cmd_sequencer.sv
// Scoreboard bench for gpu_cmd_sequencer with 4 lanes and a 16-cycle timeout.
module tb_gpu_cmd_sequencer;
    logic        clock, reset;
    logic [7:0]  s1_address;
    logic        s1_read, s1_write, s1_waitrequest, irq;
    logic [31:0] s1_readdata, s1_writedata;
    logic [1:0]  lane_op, lane_sel;
    logic [31:0] lane_arg, m1_address;
    logic        lane_start, lane_done, m1_write, m1_waitrequest;
    logic [15:0] lane_pixel, m1_writedata, pix_salt;

    int checks = 0;
    int errors = 0;
    logic [33:0] exp_op_q[$];
    logic [31:0] exp_addr_q[$];
    logic [15:0] exp_dat_q[$];
    bit done_auto = 0;
    int done_delay = 0;
    bit prev_st = 0, pend = 0;
    int dcnt = 0;

    gpu_cmd_sequencer #(.NUM_LANES(4), .CMD_DEPTH(8), .PIXEL_BITS(16), .START_CYCLES(2),
                        .TIMEOUT_CYCLES(16), .ADDR_STRIDE(2)) dut (
        .clock(clock), .reset(reset),
        .s1_address(s1_address), .s1_read(s1_read), .s1_readdata(s1_readdata),
        .s1_write(s1_write), .s1_writedata(s1_writedata), .s1_waitrequest(s1_waitrequest),
        .irq(irq), .lane_op(lane_op), .lane_arg(lane_arg), .lane_start(lane_start),
        .lane_done(lane_done), .lane_sel(lane_sel), .lane_pixel(lane_pixel),
        .m1_address(m1_address), .m1_writedata(m1_writedata), .m1_write(m1_write),
        .m1_waitrequest(m1_waitrequest)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign lane_pixel = pix_salt + 16'(lane_sel) * 16'h0101;

    // Lane model: raise lane_done for one cycle, done_delay cycles after lane_start falls.
    always @(negedge clock) begin
        lane_done = 1'b0;
        if (!done_auto) pend = 0;
        else begin
            if (prev_st && !lane_start) begin pend = 1; dcnt = done_delay; end
            if (pend) begin
                if (dcnt == 0) begin lane_done = 1'b1; pend = 0; end
                else dcnt--;
            end
        end
        prev_st = lane_start;
    end

    task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
        s1_address = a; s1_writedata = d; s1_write = 1'b1;
        @(negedge clock);
        s1_write = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
        s1_address = a; s1_read = 1'b1;
        #1 d = s1_readdata;
        @(negedge clock);
        s1_read = 1'b0;
    endtask

    task automatic push_cmd(input logic [1:0] op, input logic [31:0] arg);
        if (op == 2'd2) begin
            for (int i = 0; i < 4; i++) begin
                exp_addr_q.push_back(arg + 32'(2 * i));
                exp_dat_q.push_back(pix_salt + 16'(i * 16'h0101));
            end
        end else exp_op_q.push_back({op, arg});
        bus_write({6'd0, op}, arg);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        checks++; if (m1_write !== 1'b0) begin errors++; $display("FAIL reset_m1_write got %0b want 0", m1_write); end
        checks++; if (lane_start !== 1'b0) begin errors++; $display("FAIL reset_lane_start got %0b want 0", lane_start); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %0b want 0", irq); end
        checks++; if ({lane_op, lane_sel} !== 4'd0) begin errors++; $display("FAIL reset_op_sel got %h want 0", {lane_op, lane_sel}); end
        checks++; if ({lane_arg, m1_address} !== 64'd0) begin errors++; $display("FAIL reset_arg_addr got %h want 0", {lane_arg, m1_address}); end
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        bus_read(8'h0f, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL reset_status got %h want 0", d); end
        checks++; if (s1_waitrequest !== 1'b0) begin errors++; $display("FAIL waitrequest got %0b want 0", s1_waitrequest); end
    endtask

    task automatic test_single();
        logic [31:0] d;
        logic [33:0] e;
        int hi = 0, fall_cyc = -1, irq_cyc = -1;
        bit prev = 0;
        bus_write(8'h04, 32'd1);
        bus_read(8'h04, d);
        checks++; if (d !== 32'd1) begin errors++; $display("FAIL irq_en_read got %h want 1", d); end
        done_auto = 1; done_delay = 3;
        push_cmd(2'd1, 32'h5);
        for (int cyc = 0; cyc < 60 && irq_cyc < 0; cyc++) begin
            #1;
            if (lane_start) hi++;
            if (lane_start && !prev) begin
                checks++;
                if (exp_op_q.size() == 0) begin errors++; $display("FAIL single_op got unexpected start want none"); end
                else begin
                    e = exp_op_q.pop_front();
                    if ({lane_op, lane_arg} !== e) begin errors++; $display("FAIL single_op got %h want %h", {lane_op, lane_arg}, e); end
                end
            end
            if (!lane_start && prev) fall_cyc = cyc;
            if (irq) irq_cyc = cyc;
            prev = lane_start;
            @(negedge clock);
        end
        checks++; if (hi != 2) begin errors++; $display("FAIL start_width got %0d want 2", hi); end
        checks++; if (irq_cyc < 0 || fall_cyc < 0 || irq_cyc - fall_cyc != 5) begin
            errors++; $display("FAIL drain_irq_timing got %0d want 5", irq_cyc - fall_cyc); end
        bus_read(8'h0f, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL single_status got %h want 0", d); end
        #1;
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL drain_clear_irq got %0b want 0", irq); end
        @(negedge clock);
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        logic [33:0] e;
        int cyc = 0, first_start = -1, first_write = -1;
        bit prev = 0;
        pix_salt = 16'h1200; done_auto = 1; done_delay = 0;
        push_cmd(2'd0, 32'h11);
        push_cmd(2'd1, 32'h22);
        push_cmd(2'd2, 32'h1000);
        while ((exp_addr_q.size() > 0 || exp_op_q.size() > 0) && cyc < 100) begin
            #1;
            if (lane_start && !prev) begin
                if (first_start < 0) first_start = cyc;
                checks++;
                if (exp_op_q.size() == 0) begin errors++; $display("FAIL b2b_op got unexpected start want none"); end
                else begin
                    e = exp_op_q.pop_front();
                    if ({lane_op, lane_arg} !== e) begin errors++; $display("FAIL b2b_op got %h want %h", {lane_op, lane_arg}, e); end
                end
            end
            prev = lane_start;
            if (m1_write && !m1_waitrequest) begin
                if (first_write < 0) first_write = cyc;
                checks++;
                if (exp_addr_q.size() == 0) begin errors++; $display("FAIL b2b_write got extra %h want none", m1_address); end
                else begin
                    d = exp_addr_q.pop_front();
                    e = 34'(exp_dat_q.pop_front());
                    if (m1_address !== d || 34'(m1_writedata) !== e) begin
                        errors++; $display("FAIL b2b_write got %h/%h want %h/%h", m1_address, m1_writedata, d, e[15:0]); end
                end
            end
            @(negedge clock); cyc++;
        end
        checks++; if (exp_addr_q.size() != 0 || exp_op_q.size() != 0) begin
            errors++; $display("FAIL b2b_drain got %0d left want 0", exp_addr_q.size() + exp_op_q.size()); end
        checks++; if (first_write - first_start != 8) begin
            errors++; $display("FAIL b2b_gap got %0d want 8", first_write - first_start); end
        repeat (3) @(negedge clock);
        bus_read(8'h0f, d);
    endtask

    task automatic test_stall();
        logic [31:0] d, ea;
        logic [15:0] ed;
        int cyc = 0, stall_left = 0, stall_seen = 0;
        bit started = 0;
        pix_salt = 16'h3400;
        push_cmd(2'd2, 32'h2000);
        while (exp_addr_q.size() > 0 && cyc < 100) begin
            #1;
            if (m1_write && m1_address == 32'h2002 && !started) begin started = 1; stall_left = 5; end
            m1_waitrequest = (stall_left > 0);
            if (stall_left > 0) begin
                stall_left--; stall_seen++;
                checks++;
                if (m1_write !== 1'b1 || m1_address !== 32'h2002 || m1_writedata !== 16'h3501) begin
                    errors++; $display("FAIL stall_hold got %0b/%h/%h want 1/00002002/3501", m1_write, m1_address, m1_writedata); end
            end else if (m1_write) begin
                checks++;
                if (exp_addr_q.size() == 0) begin errors++; $display("FAIL stall_write got extra %h want none", m1_address); end
                else begin
                    ea = exp_addr_q.pop_front(); ed = exp_dat_q.pop_front();
                    if (m1_address !== ea || m1_writedata !== ed) begin
                        errors++; $display("FAIL stall_write got %h/%h want %h/%h", m1_address, m1_writedata, ea, ed); end
                end
            end
            @(negedge clock); cyc++;
        end
        m1_waitrequest = 1'b0;
        checks++; if (stall_seen != 5 || exp_addr_q.size() != 0) begin
            errors++; $display("FAIL stall_count got %0d/%0d want 5/0", stall_seen, exp_addr_q.size()); end
        repeat (3) @(negedge clock);
        bus_read(8'h0f, d);
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        done_auto = 0;
        bus_write(8'h00, 32'h1);
        repeat (4) @(negedge clock);
        for (int i = 0; i < 9; i++) bus_write(8'h01, 32'(i));
        bus_read(8'h0f, d);
        checks++; if (d !== 32'h0000_0806) begin errors++; $display("FAIL ovf_status got %h want 00000806", d); end
        bus_write(8'h0f, 32'h1);
        bus_read(8'h0f, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL flush_status got %h want 0", d); end
        checks++; if (lane_start !== 1'b0 || m1_write !== 1'b0) begin
            errors++; $display("FAIL flush_idle got %0b/%0b want 0/0", lane_start, m1_write); end
    endtask

    task automatic test_timeout();
        logic [31:0] d;
        int wstart = -1, k = -1;
        bit prev = 0;
        bus_write(8'h04, 32'd2);
        done_auto = 0;
        bus_write(8'h03, 32'h7);
        for (int cyc = 0; cyc < 80 && k < 0; cyc++) begin
            #1;
            if (prev && !lane_start) begin
                wstart = cyc;
                checks++; if (irq !== 1'b0) begin errors++; $display("FAIL tmo_early_irq got %0b want 0", irq); end
            end
            if (irq && wstart >= 0) k = cyc - wstart;
            prev = lane_start;
            @(negedge clock);
        end
        checks++; if (k != 16) begin errors++; $display("FAIL tmo_latency got %0d want 16", k); end
        checks++; if (lane_op !== 2'd3 || lane_arg !== 32'h7) begin
            errors++; $display("FAIL tmo_cmd got %0d/%h want 3/7", lane_op, lane_arg); end
        bus_read(8'h0f, d);
        checks++; if (d !== 32'h0000_000A) begin errors++; $display("FAIL tmo_status got %h want 0000000a", d); end
        bus_write(8'h0f, 32'h1);
    endtask

    task automatic test_reset_mid_write();
        logic [31:0] d;
        int cyc = 0;
        bus_write(8'h04, 32'd3);
        m1_waitrequest = 1'b1; done_auto = 1; done_delay = 0;
        bus_write(8'h02, 32'h3000);
        while (!m1_write && cyc < 20) begin @(negedge clock); #1; cyc++; end
        checks++; if (m1_write !== 1'b1 || m1_address !== 32'h3000) begin
            errors++; $display("FAIL prereset_write got %0b/%h want 1/00003000", m1_write, m1_address); end
        #2 reset = 1'b0;
        #1;
        checks++; if (m1_write !== 1'b0 || m1_address !== 32'd0) begin
            errors++; $display("FAIL async_reset got %0b/%h want 0/0", m1_write, m1_address); end
        checks++; if (irq !== 1'b0 || lane_op !== 2'd0) begin
            errors++; $display("FAIL async_reset_irq_op got %0b/%0d want 0/0", irq, lane_op); end
        @(negedge clock);
        reset = 1'b1; m1_waitrequest = 1'b0;
        @(negedge clock);
        bus_read(8'h0f, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL post_reset_status got %h want 0", d); end
        bus_read(8'h04, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL post_reset_irq_en got %h want 0", d); end
        bus_read(8'h08, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL perf_addr got %h want 0", d); end
    endtask

    initial begin
        reset = 1'b0; s1_address = '0; s1_read = 1'b0; s1_write = 1'b0; s1_writedata = '0;
        m1_waitrequest = 1'b0; pix_salt = 16'h0;
        repeat (2) @(negedge clock);
        #1;
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_overflow();
        test_timeout();
        test_reset_mid_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
